verify_feeder: RTL and testbench

VERIFY_FEEDER -- requirements
Module: verify_feeder

---
 rtl/verify_feeder_pkg.sv | 97 +++++++++
 rtl/stream_skid2.sv | 57 +++++
 rtl/verify_feeder.sv | 199 +++++++++++++++++++
 tb/tb_verify_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_feeder_pkg.sv
// Shared definitions for the signature-verify feeder.
//   field_t      : field-memory selector driven on rd_sel_o
//   state_t      : feeder FSM state, also exported for debug
//   *_WORDS_NUM  : per-field word counts at the default width/level
//   VERIFY_MODE  : core_mode_o encoding for a verify job
//   helpers      : word counts for any stream width and security level
package verify_feeder_pkg;

  localparam int unsigned W_DEFAULT         = 64;
  localparam int unsigned SEC_LEVEL_DEFAULT = 2;
  localparam logic [1:0]  VERIFY_MODE       = 2'd2;
  localparam int unsigned NUM_FIELDS        = 7;

  typedef enum logic [2:0] {
    F_RHO  = 3'd0,
    F_C    = 3'd1,
    F_Z    = 3'd2,
    F_T1   = 3'd3,
    F_H    = 3'd4,
    F_MLEN = 3'd5,
    F_MSG  = 3'd6
  } field_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRST   = 3'd1,
    S_CSTART = 3'd2,
    S_FEED   = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic int unsigned bytes_to_words(int unsigned nbytes, int unsigned w);
    return (nbytes * 8 + w - 1) / w;
  endfunction

  // Packed byte sizes: z uses 18-bit coefficients at level 2, 20-bit above;
  // t1 is K polys of 320 bytes; h is omega + K bytes.
  function automatic int unsigned seed_words_num(int unsigned w);
    return bytes_to_words(32, w);
  endfunction

  function automatic int unsigned z_words_num(int unsigned sec, int unsigned w);
    case (sec)
      3:       return bytes_to_words(5 * 640, w);
      5:       return bytes_to_words(7 * 640, w);
      default: return bytes_to_words(4 * 576, w);
    endcase
  endfunction

  function automatic int unsigned t1_words_num(int unsigned sec, int unsigned w);
    case (sec)
      3:       return bytes_to_words(6 * 320, w);
      5:       return bytes_to_words(8 * 320, w);
      default: return bytes_to_words(4 * 320, w);
    endcase
  endfunction

  function automatic int unsigned h_words_num(int unsigned sec, int unsigned w);
    case (sec)
      3:       return bytes_to_words(55 + 6, w);
      5:       return bytes_to_words(75 + 8, w);
      default: return bytes_to_words(80 + 4, w);
    endcase
  endfunction

  localparam int unsigned SEED_WORDS_NUM = seed_words_num(W_DEFAULT);
  localparam int unsigned Z_WORDS_NUM    = z_words_num(SEC_LEVEL_DEFAULT, W_DEFAULT);
  localparam int unsigned T1_WORDS_NUM   = t1_words_num(SEC_LEVEL_DEFAULT, W_DEFAULT);
  localparam int unsigned H_WORDS_NUM    = h_words_num(SEC_LEVEL_DEFAULT, W_DEFAULT);

  // Field sequence for one job; idx runs 0..NUM_FIELDS-1.
  function automatic field_t field_at(bit high_perf, logic [2:0] idx);
    if (high_perf) begin
      case (idx)
        3'd0:    return F_RHO;
        3'd1:    return F_C;
        3'd2:    return F_Z;
        3'd3:    return F_T1;
        3'd4:    return F_MLEN;
        3'd5:    return F_MSG;
        default: return F_H;
      endcase
    end else begin
      case (idx)
        3'd0:    return F_RHO;
        3'd1:    return F_T1;
        3'd2:    return F_C;
        3'd3:    return F_Z;
        3'd4:    return F_H;
        3'd5:    return F_MLEN;
        default: return F_MSG;
      endcase
    end
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer between the field-memory read pipeline and
// the core input stream.
//   in_valid_i/in_data_i   : push side; the producer tracks credit through
//                            count_o and never pushes into a full buffer
//   out_valid_o/out_data_o : pop side, head entry; holds while out_ready_i=0
//   out_ready_i            : consumer accepts the head entry
//   count_o                : current occupancy (0..2)
// Valid/ready: a word moves when valid && ready at a rising edge; once valid
// is high it stays high with stable data until that happens.
module stream_skid2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot0_q;
  assign count_o     = count_q;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop     = out_valid_o && out_ready_i;
    if (pop && count_q == 2'd2) slot0_d = slot1_q;
    if (in_valid_i) begin
      // New word lands in the first slot that is free after the pop.
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) slot0_d = in_data_i;
      else                                              slot1_d = in_data_i;
    end
    count_d = count_q + {1'b0, in_valid_i} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/verify_feeder.sv
// Sequences one signature-verify job on the dilithium core: resets and
// starts the core, streams the signature/key/message fields from the field
// memory into the core, then captures the accept/reject result.
//   start_i, mlen_i                  : job request and message length (bytes)
//   busy_o, done_o, reject_o, cycles_o : job status
//   rd_en_o/rd_sel_o/rd_addr_o, rd_data_i : field memory, 1-cycle read latency
//   core_rst_o/core_start_o/core_mode_o   : core control
//   core_valid_o/core_ready_i/core_data_o : stream into the core
//   core_valid_i/core_ready_o/core_data_i : result stream from the core
//   dbg_state_o                      : FSM state
module verify_feeder
  import verify_feeder_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int          HIGH_PERF = 1,
  parameter int unsigned SEC_LEVEL = SEC_LEVEL_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic         busy_o,
  output logic         rd_en_o,
  output field_t       rd_sel_o,
  output logic [9:0]   rd_addr_o,
  input  logic [W-1:0] rd_data_i,
  input  logic [31:0]  mlen_i,
  output logic         core_rst_o,
  output logic         core_start_o,
  output logic [1:0]   core_mode_o,
  output logic         core_valid_o,
  input  logic         core_ready_i,
  output logic [W-1:0] core_data_o,
  input  logic         core_valid_i,
  output logic         core_ready_o,
  input  logic [W-1:0] core_data_i,
  output logic         done_o,
  output logic         reject_o,
  output logic [31:0]  cycles_o,
  output state_t       dbg_state_o
);

  localparam logic [31:0] SEED_WN = 32'(seed_words_num(W));
  localparam logic [31:0] Z_WN    = 32'(z_words_num(SEC_LEVEL, W));
  localparam logic [31:0] T1_WN   = 32'(t1_words_num(SEC_LEVEL, W));
  localparam logic [31:0] H_WN    = 32'(h_words_num(SEC_LEVEL, W));

  state_t      state_q, state_d;
  logic [1:0]  crst_cnt_q, crst_cnt_d;
  logic [31:0] mlen_q, mlen_d;
  logic [31:0] msg_words_q, msg_words_d;
  logic [2:0]  fidx_q, fidx_d;       // field being fetched
  logic [31:0] k_q, k_d;             // word index inside that field
  logic        iss_done_q, iss_done_d;
  logic        pend_q, pend_mlen_q;  // read in flight, and whether it is the MLEN word
  logic        reject_q, reject_d;
  logic [31:0] cycles_q, cycles_d;

  field_t      cur_field;
  logic [31:0] cur_len;
  logic [34:0] msg_w;
  logic [1:0]  skid_count;
  logic [2:0]  credit_used;
  logic        pop, issue, last_xfer;
  logic [W-1:0] push_data;

  stream_skid2 #(.W(W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (pend_q),
    .in_data_i   (push_data),
    .out_valid_o (core_valid_o),
    .out_data_o  (core_data_o),
    .out_ready_i (core_ready_i),
    .count_o     (skid_count)
  );

  assign push_data = pend_mlen_q ? W'(mlen_q) : rd_data_i;

  always_comb begin
    cur_field = field_at(HIGH_PERF != 0, fidx_q);
    case (cur_field)
      F_RHO, F_C: cur_len = SEED_WN;
      F_Z:        cur_len = Z_WN;
      F_T1:       cur_len = T1_WN;
      F_H:        cur_len = H_WN;
      F_MSG:      cur_len = msg_words_q;
      default:    cur_len = 32'd1;
    endcase

    // A read issued now lands in the buffer next cycle, so buffered words
    // plus the one in flight, less the one leaving now, must leave a slot.
    pop         = core_valid_o && core_ready_i;
    credit_used = {1'b0, skid_count} + {2'b0, pend_q};
    issue       = (state_q == S_CSTART || state_q == S_FEED) && !iss_done_q &&
                  (credit_used <= (3'd1 + {2'b0, pop}));
    last_xfer   = pop && iss_done_q && !pend_q && (skid_count == 2'd1);

    rd_en_o   = issue && (cur_field != F_MLEN);
    rd_sel_o  = rd_en_o ? cur_field : F_RHO;
    rd_addr_o = rd_en_o ? k_q[9:0] : 10'd0;

    fidx_d     = fidx_q;
    k_d        = k_q;
    iss_done_d = iss_done_q;
    if (issue) begin
      if (k_q == cur_len - 32'd1) begin
        k_d = 32'd0;
        if (fidx_q == 3'(NUM_FIELDS - 1)) iss_done_d = 1'b1;
        else                              fidx_d     = fidx_q + 3'd1;
      end else begin
        k_d = k_q + 32'd1;
      end
    end

    msg_w       = ({mlen_i, 3'b000} + 35'(W - 1)) / 35'(W);
    state_d     = state_q;
    crst_cnt_d  = crst_cnt_q;
    mlen_d      = mlen_q;
    msg_words_d = msg_words_q;
    reject_d    = reject_q;
    cycles_d    = cycles_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_CRST;
          mlen_d      = mlen_i;
          msg_words_d = (msg_w == 35'd0) ? 32'd1 : 32'(msg_w);
          crst_cnt_d  = 2'd0;
          fidx_d      = 3'd0;
          k_d         = 32'd0;
          iss_done_d  = 1'b0;
        end
      end
      S_CRST: begin
        crst_cnt_d = crst_cnt_q + 2'd1;
        if (crst_cnt_q == 2'd3) state_d = S_CSTART;
      end
      S_CSTART: begin
        // Count restarts here; the CSTART cycle itself is the first one.
        cycles_d = 32'd1;
        reject_d = 1'b0;
        state_d  = S_FEED;
      end
      S_FEED: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (last_xfer) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (core_valid_i) begin
          reject_d = (core_data_i == W'(1));
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      crst_cnt_q  <= 2'd0;
      mlen_q      <= 32'd0;
      msg_words_q <= 32'd0;
      fidx_q      <= 3'd0;
      k_q         <= 32'd0;
      iss_done_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_mlen_q <= 1'b0;
      reject_q    <= 1'b0;
      cycles_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      crst_cnt_q  <= crst_cnt_d;
      mlen_q      <= mlen_d;
      msg_words_q <= msg_words_d;
      fidx_q      <= fidx_d;
      k_q         <= k_d;
      iss_done_q  <= iss_done_d;
      pend_q      <= issue;
      pend_mlen_q <= issue && (cur_field == F_MLEN);
      reject_q    <= reject_d;
      cycles_q    <= cycles_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign core_rst_o   = (state_q == S_CRST);
  assign core_start_o = (state_q == S_CSTART);
  assign core_ready_o = (state_q == S_RESULT);
  assign core_mode_o  = VERIFY_MODE;
  assign reject_o     = reject_q;
  assign cycles_o     = cycles_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_verify_feeder.sv
module tb_verify_feeder;
  import verify_feeder_pkg::*;

  localparam int W      = 64;
  // Word counts for W=64, level 2, derived from the packed byte sizes.
  localparam int SEED_N = 4;    // 32 bytes
  localparam int Z_N    = 288;  // 4 polys * 576 bytes
  localparam int T1_N   = 160;  // 4 polys * 320 bytes
  localparam int H_N    = 11;   // 84 bytes

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // unit 0: HIGH_PERF=1, unit 1: HIGH_PERF=0
  logic         start_i      [2];
  logic         busy_o       [2];
  logic         rd_en_o      [2];
  field_t       rd_sel_o     [2];
  logic [9:0]   rd_addr_o    [2];
  logic [W-1:0] rd_data_i    [2];
  logic [31:0]  mlen_i       [2];
  logic         core_rst_o   [2];
  logic         core_start_o [2];
  logic [1:0]   core_mode_o  [2];
  logic         core_valid_o [2];
  logic         core_ready_i [2];
  logic [W-1:0] core_data_o  [2];
  logic         core_valid_i [2];
  logic         core_ready_o [2];
  logic [W-1:0] core_data_i  [2];
  logic         done_o       [2];
  logic         reject_o     [2];
  logic [31:0]  cycles_o     [2];
  state_t       dbg_state_o  [2];

  function automatic logic [W-1:0] word_fn(field_t f, logic [9:0] a);
    return {16'hD1A0, 5'b0, f, 6'b0, a, 24'h5A5A5A};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    verify_feeder #(.W(W), .HIGH_PERF(1 - g), .SEC_LEVEL(2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i[g]),
      .busy_o       (busy_o[g]),
      .rd_en_o      (rd_en_o[g]),
      .rd_sel_o     (rd_sel_o[g]),
      .rd_addr_o    (rd_addr_o[g]),
      .rd_data_i    (rd_data_i[g]),
      .mlen_i       (mlen_i[g]),
      .core_rst_o   (core_rst_o[g]),
      .core_start_o (core_start_o[g]),
      .core_mode_o  (core_mode_o[g]),
      .core_valid_o (core_valid_o[g]),
      .core_ready_i (core_ready_i[g]),
      .core_data_o  (core_data_o[g]),
      .core_valid_i (core_valid_i[g]),
      .core_ready_o (core_ready_o[g]),
      .core_data_i  (core_data_i[g]),
      .done_o       (done_o[g]),
      .reject_o     (reject_o[g]),
      .cycles_o     (cycles_o[g]),
      .dbg_state_o  (dbg_state_o[g])
    );

    // field memory model, one-cycle read latency
    always @(posedge clk) begin
      if (rd_en_o[g]) rd_data_i[g] <= word_fn(rd_sel_o[g], rd_addr_o[g]);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic field_t exp_field(int hp, int idx);
    if (hp != 0) begin
      case (idx)
        0: return F_RHO;  1: return F_C;    2: return F_Z;  3: return F_T1;
        4: return F_MLEN; 5: return F_MSG;  default: return F_H;
      endcase
    end else begin
      case (idx)
        0: return F_RHO;  1: return F_T1;   2: return F_C;  3: return F_Z;
        4: return F_H;    5: return F_MLEN; default: return F_MSG;
      endcase
    end
  endfunction

  function automatic int exp_len(field_t f, int msgw);
    case (f)
      F_RHO, F_C: return SEED_N;
      F_Z:        return Z_N;
      F_T1:       return T1_N;
      F_H:        return H_N;
      F_MLEN:     return 1;
      default:    return msgw;
    endcase
  endfunction

  task automatic fill_expect(input int u, input int unsigned mlen);
    longint unsigned mw;
    int msgw;
    field_t f;
    mw   = (longint'(mlen) * 8 + 63) / 64;
    msgw = (mw == 0) ? 1 : int'(mw);
    exp_q.delete();
    for (int idx = 0; idx < 7; idx++) begin
      f = exp_field((u == 0) ? 1 : 0, idx);
      if (f == F_MLEN) exp_q.push_back(W'(mlen));
      else for (int k = 0; k < exp_len(f, msgw); k++) exp_q.push_back(word_fn(f, 10'(k)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; mode 1: ready repeats 1,0,0,1
  task automatic run_job(input int u, input int unsigned mlen, input int mode,
                         input logic [W-1:0] result, input bit poke, input logic exp_reject);
    int c, c_start, c_first, c_cap, c_fx, c_lx, nwords, exp_n;
    bit prev_stall, got_done;
    logic [W-1:0] prev_data, exp;
    c = 0; c_start = -1; c_first = -1; c_cap = -1; c_fx = -1; c_lx = -1; nwords = 0;
    prev_stall = 1'b0; got_done = 1'b0; prev_data = '0;
    fill_expect(u, mlen);
    exp_n = exp_q.size();
    mlen_i[u]  = mlen;
    start_i[u] = 1'b1;
    tick();
    start_i[u] = 1'b0;
    total++;
    if (busy_o[u] !== 1'b1) begin
      bad++; $display("FAIL accept u%0d: busy=%b want 1", u, busy_o[u]);
    end
    while (c < 5000 && !got_done) begin
      core_ready_i[u] = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
      if (core_start_o[u] && c_start < 0) c_start = c;
      if (core_valid_o[u] && c_first < 0) c_first = c;
      if (prev_stall) begin
        total++;
        if (core_valid_o[u] !== 1'b1 || core_data_o[u] !== prev_data) begin
          bad++; $display("FAIL stall_hold u%0d c=%0d: valid=%b data=%h want 1 %h",
                          u, c, core_valid_o[u], core_data_o[u], prev_data);
        end
      end
      if (core_valid_o[u] && core_ready_i[u]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_word u%0d: data=%h want none", u, core_data_o[u]);
        end else begin
          exp = exp_q.pop_front();
          if (core_data_o[u] !== exp) begin
            bad++; $display("FAIL word u%0d #%0d: data=%h want %h", u, nwords, core_data_o[u], exp);
          end
        end
        if (c_fx < 0) c_fx = c;
        c_lx = c;
        nwords++;
      end
      prev_stall = core_valid_o[u] && !core_ready_i[u];
      prev_data  = core_data_o[u];
      core_valid_i[u] = core_ready_o[u];
      core_data_i[u]  = result;
      if (core_ready_o[u] && core_valid_i[u]) c_cap = c;
      if (done_o[u]) begin
        got_done = 1'b1;
        total++;
        if (busy_o[u] !== 1'b0 || reject_o[u] !== exp_reject) begin
          bad++; $display("FAIL done_status u%0d: busy=%b reject=%b want 0 %b",
                          u, busy_o[u], reject_o[u], exp_reject);
        end
        total++;
        if (cycles_o[u] !== 32'(c_cap - c_start + 1)) begin
          bad++; $display("FAIL cycles u%0d: got %0d want %0d", u, cycles_o[u], c_cap - c_start + 1);
        end
      end
      start_i[u] = poke && (nwords == 10 || done_o[u]);
      tick();
      c++;
    end
    start_i[u] = 1'b0; core_valid_i[u] = 1'b0; core_ready_i[u] = 1'b0;
    total++;
    if (!got_done) begin
      bad++; $display("FAIL timeout u%0d: no done_o after %0d cycles", u, c);
    end
    total++;
    if (nwords != exp_n || exp_q.size() != 0) begin
      bad++; $display("FAIL word_count u%0d: got %0d want %0d", u, nwords, exp_n);
    end
    total++;
    if (c_first - c_start != 2) begin
      bad++; $display("FAIL first_valid u%0d: got %0d cycles after CSTART want 2", u, c_first - c_start);
    end
    if (mode == 0) begin
      total++;
      if (c_lx - c_fx + 1 != exp_n) begin
        bad++; $display("FAIL contiguous u%0d: span=%0d want %0d", u, c_lx - c_fx + 1, exp_n);
      end
    end
    total++;
    if (done_o[u] !== 1'b0 || busy_o[u] !== 1'b0) begin
      bad++; $display("FAIL done_pulse u%0d: done=%b busy=%b want 0 0", u, done_o[u], busy_o[u]);
    end
    tick(); tick();
    total++;
    if (busy_o[u] !== 1'b0 || reject_o[u] !== exp_reject || dbg_state_o[u] !== S_IDLE) begin
      bad++; $display("FAIL idle_hold u%0d: busy=%b reject=%b state=%0d want 0 %b 0",
                      u, busy_o[u], reject_o[u], dbg_state_o[u], exp_reject);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({busy_o[u], rd_en_o[u], core_rst_o[u], core_start_o[u], core_valid_o[u],
           core_ready_o[u], done_o[u], reject_o[u]} !== 8'b0 ||
          {rd_sel_o[u], rd_addr_o[u]} !== 13'b0 || core_data_o[u] !== '0 ||
          cycles_o[u] !== 32'd0 || dbg_state_o[u] !== S_IDLE || core_mode_o[u] !== VERIFY_MODE) begin
        bad++; $display("FAIL reset_outputs u%0d: busy=%b valid=%b cycles=%0d state=%0d mode=%0d",
                        u, busy_o[u], core_valid_o[u], cycles_o[u], dbg_state_o[u], core_mode_o[u]);
      end
    end
  endtask

  task automatic test_crst_len;
    int n;
    n = 0;
    mlen_i[0] = 32'd8; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (core_rst_o[0]) n++;
      tick();
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL crst_len: core_rst_o high %0d cycles want 4", n);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset_mid_t1(input int u);
    int c;
    c = 0;
    mlen_i[u] = 32'd16; start_i[u] = 1'b1;
    tick();
    start_i[u] = 1'b0;
    core_ready_i[u] = 1'b1;
    while (c < 2000 && !(rd_en_o[u] && rd_sel_o[u] == F_T1 && rd_addr_o[u] == 10'd5)) begin
      tick(); c++;
    end
    total++;
    if (c >= 2000) begin
      bad++; $display("FAIL t1_reach u%0d: no T1 read within %0d cycles", u, c);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({busy_o[u], rd_en_o[u], core_rst_o[u], core_start_o[u], core_valid_o[u],
         core_ready_o[u], done_o[u], reject_o[u]} !== 8'b0 ||
        core_data_o[u] !== '0 || cycles_o[u] !== 32'd0 || dbg_state_o[u] !== S_IDLE ||
        core_mode_o[u] !== VERIFY_MODE) begin
      bad++; $display("FAIL mid_reset u%0d: busy=%b valid=%b cycles=%0d state=%0d",
                      u, busy_o[u], core_valid_o[u], cycles_o[u], dbg_state_o[u]);
    end
    rst = 1'b0;
    core_ready_i[u] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_i[u] = 1'b0; mlen_i[u] = '0; core_ready_i[u] = 1'b0;
      core_valid_i[u] = 1'b0; core_data_i[u] = '0;
    end
    tick(); tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_crst_len();
    run_job(0, 33, 0, 64'd0, 1'b0, 1'b0);                          // 5 MSG words
    run_job(1, 0, 0, 64'd1, 1'b0, 1'b1);                           // 1 MSG word
    run_job(0, $urandom_range(1, 100), 1, 64'd1, 1'b0, 1'b1);      // stalls
    run_job(1, $urandom_range(1, 100), 1, 64'd0, 1'b0, 1'b0);
    test_reset_mid_t1(0);
    run_job(0, 16, 0, 64'd1, 1'b0, 1'b1);                          // restart from RHO 0
    run_job(1, 20, 0, 64'd2, 1'b1, 1'b0);                          // start pokes ignored
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
